traceback_controller: RTL

//  Sequences the traceback Processing datapath after matrix fill completes.
//  - Walks (i,j) from (N,M) back to the origin.
//  - Reads the stored direction symbol and both sequence characters for each cell.
//  - Presents each step to Processing as a single en_traceB pulse with symbol/SeqA_i_t/SeqB_j_t.
//  - Asserts done once the origin is reached.

---
 rtl/traceback_controller_pkg.sv | 27 ++
 rtl/traceback_controller_if.sv | 26 ++
 rtl/traceback_controller_index.sv | 79 +++++++
 rtl/traceback_controller.sv | 128 ++++++++++++
 4 files changed

// File: rtl/traceback_controller_pkg.sv
// Shared encodings for the traceback controller: direction symbols, base codes and FSM states.
package traceback_controller_pkg;

  localparam logic [2:0] DIR_DIAG = 3'b001;
  localparam logic [2:0] DIR_UP   = 3'b010;
  localparam logic [2:0] DIR_LEFT = 3'b100;

  localparam logic [2:0] BASE_A   = 3'b100;
  localparam logic [2:0] BASE_G   = 3'b001;
  localparam logic [2:0] BASE_T   = 3'b011;
  localparam logic [2:0] BASE_C   = 3'b110;
  localparam logic [2:0] BASE_GAP = 3'b000;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StWait,
    StStep,
    StFin,
    StErr
  } state_e;

  function automatic logic is_legal_dir(input logic [2:0] dir);
    return dir inside {DIR_DIAG, DIR_UP, DIR_LEFT};
  endfunction

endpackage

// File: rtl/traceback_controller_if.sv
// Memory read port and Processing step port of the traceback controller.
interface traceback_controller_if #(
  parameter int unsigned IW = 3,
  parameter int unsigned JW = 3
);
  logic [IW-1:0] addr_i;
  logic [JW-1:0] addr_j;
  logic          rd_en;
  logic [2:0]    dir_rd;
  logic [2:0]    seqA_rd;
  logic [2:0]    seqB_rd;
  logic          en_traceB;
  logic [2:0]    symbol;
  logic [2:0]    SeqA_i_t;
  logic [2:0]    SeqB_j_t;

  modport master (
    output addr_i, addr_j, rd_en, en_traceB, symbol, SeqA_i_t, SeqB_j_t,
    input  dir_rd, seqA_rd, seqB_rd
  );

  modport slave (
    input  addr_i, addr_j, rd_en, en_traceB, symbol, SeqA_i_t, SeqB_j_t,
    output dir_rd, seqA_rd, seqB_rd
  );
endinterface

// File: rtl/traceback_controller_index.sv
// (i,j) down-counters with load, boundary direction forcing, legality and origin detection.
module traceback_controller_index
  import traceback_controller_pkg::*;
#(
  parameter int unsigned N  = 5,
  parameter int unsigned M  = 5,
  parameter int unsigned IW = 3,
  parameter int unsigned JW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          step,
  input  logic [2:0]    sym,
  input  logic [2:0]    dir_raw,
  output logic [IW-1:0] i,
  output logic [JW-1:0] j,
  output logic [2:0]    eff_dir,
  output logic          illegal,
  output logic          origin_next
);

  logic [IW-1:0] i_q, i_d, step_i;
  logic [JW-1:0] j_q, j_d, step_j;
  logic          i_zero, j_zero;

  assign i_zero = (i_q == '0);
  assign j_zero = (j_q == '0);

  // Zero guards keep a stray symbol from wrapping an index below the origin.
  always_comb begin
    step_i = i_q;
    step_j = j_q;
    if ((sym == DIR_DIAG || sym == DIR_UP) && !i_zero) begin
      step_i = i_q - IW'(1);
    end
    if ((sym == DIR_DIAG || sym == DIR_LEFT) && !j_zero) begin
      step_j = j_q - JW'(1);
    end
  end

  always_comb begin
    i_d = i_q;
    j_d = j_q;
    if (load) begin
      i_d = IW'(N);
      j_d = JW'(M);
    end else if (step) begin
      i_d = step_i;
      j_d = step_j;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i_q <= IW'(N);
      j_q <= JW'(M);
    end else begin
      i_q <= i_d;
      j_q <= j_d;
    end
  end

  // On the matrix edges only one move is possible, so the stored symbol is ignored there.
  always_comb begin
    eff_dir = dir_raw;
    if (i_zero && !j_zero) begin
      eff_dir = DIR_LEFT;
    end else if (j_zero && !i_zero) begin
      eff_dir = DIR_UP;
    end
  end

  assign illegal     = !i_zero && !j_zero && !is_legal_dir(dir_raw);
  assign origin_next = (step_i == '0) && (step_j == '0);
  assign i           = i_q;
  assign j           = j_q;

endmodule

// File: rtl/traceback_controller.sv
// Walks the direction matrix from (N,M) to the origin, issuing one Processing step per cell.
module traceback_controller
  import traceback_controller_pkg::*;
#(
  parameter int unsigned N  = 5,
  parameter int unsigned M  = 5,
  parameter int unsigned IW = 3,
  parameter int unsigned JW = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  traceback_controller_if.master bus,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int unsigned CW = $clog2(N + M + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] step_cnt_q, step_cnt_d;
  logic [2:0]    sym_q, sym_d, a_q, a_d, b_q, b_d;
  logic          err_q, err_d;
  logic          load, step, capture;
  logic [IW-1:0] idx_i;
  logic [JW-1:0] idx_j;
  logic [2:0]    eff_dir;
  logic          illegal, origin_next;

  traceback_controller_index #(
    .N  (N),
    .M  (M),
    .IW (IW),
    .JW (JW)
  ) u_index (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .step        (step),
    .sym         (sym_q),
    .dir_raw     (bus.dir_rd),
    .i           (idx_i),
    .j           (idx_j),
    .eff_dir     (eff_dir),
    .illegal     (illegal),
    .origin_next (origin_next)
  );

  always_comb begin
    state_d    = state_q;
    step_cnt_d = step_cnt_q;
    err_d      = err_q;
    load       = 1'b0;
    step       = 1'b0;
    capture    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          load       = 1'b1;
          err_d      = 1'b0;
          step_cnt_d = '0;
          state_d    = StRead;
        end
      end
      StRead: state_d = StWait;
      StWait: begin
        // Watchdog: a legal walk never needs more than N+M steps.
        if (illegal || step_cnt_q == CW'(N + M)) begin
          err_d   = 1'b1;
          state_d = StErr;
        end else begin
          capture = 1'b1;
          state_d = StStep;
        end
      end
      StStep: begin
        step       = 1'b1;
        step_cnt_d = step_cnt_q + CW'(1);
        state_d    = origin_next ? StFin : StRead;
      end
      StFin:   state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    sym_d = sym_q;
    a_d   = a_q;
    b_d   = b_q;
    if (capture) begin
      sym_d = eff_dir;
      a_d   = (eff_dir == DIR_LEFT) ? BASE_GAP : bus.seqA_rd;
      b_d   = (eff_dir == DIR_UP)   ? BASE_GAP : bus.seqB_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      step_cnt_q <= '0;
      err_q      <= 1'b0;
      sym_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
    end else begin
      state_q    <= state_d;
      step_cnt_q <= step_cnt_d;
      err_q      <= err_d;
      sym_q      <= sym_d;
      a_q        <= a_d;
      b_q        <= b_d;
    end
  end

  assign bus.addr_i    = idx_i;
  assign bus.addr_j    = idx_j;
  assign bus.rd_en     = (state_q == StRead);
  assign bus.en_traceB = (state_q == StStep);
  assign bus.symbol    = sym_q;
  assign bus.SeqA_i_t  = a_q;
  assign bus.SeqB_j_t  = b_q;
  assign busy          = (state_q == StRead) || (state_q == StWait) || (state_q == StStep);
  assign done          = (state_q == StFin);
  assign err           = err_q;

endmodule
